dmem_line_responder: RTL

//   Memory-side responder for the dcache line interface (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready).

---
 rtl/dmem_line_responder_if.sv | 24 ++
 rtl/dmem_line_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dmem_line_responder_if.sv
// Line-level memory handshake between a cache (master) and its backing memory (slave).
// The initiator holds the read/write request, address and write data until it sees mem_ready.
interface dmem_line_responder_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              proto_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, proto_err
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Fixed-latency line memory behind the cache line interface.
// It flags initiator handshake violations on a sticky error output.
module dmem_line_responder #(
    parameter int ADDR_W     = 28,
    parameter int LINE_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    dmem_line_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [LINE_W-1:0]     rdata_q;

    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  mem_we;
    logic                  req_bad;

    logic [LINE_W-1:0]     line_mem [DEPTH];

    // While a transaction is in flight the initiator must keep presenting exactly the latched request.
    always_comb begin
        req_bad = 1'b0;
        if (op_wr_q) begin
            req_bad = !(bus.mem_write && !bus.mem_read);
        end else begin
            req_bad = !(bus.mem_read && !bus.mem_write);
        end
        if (bus.mem_addr != addr_q) begin
            req_bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        rd_idx  = addr_q[DEPTH_LOG2-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    op_wr_d = bus.mem_write;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CNT_INIT;
                    if (bus.mem_read && bus.mem_write) begin
                        err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        // Nothing latched yet, so the array is addressed straight from the bus.
                        state_d = S_RESP;
                        rd_en   = !bus.mem_write;
                        rd_idx  = bus.mem_addr[DEPTH_LOG2-1:0];
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (req_bad) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    rd_en   = !op_wr_q;
                end
            end

            S_RESP: begin
                if (req_bad) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            if (rd_en) begin
                rdata_q <= line_mem[rd_idx];
            end
        end
    end

    // The write lands on the edge that ends RESP; a reset in that cycle discards it.
    assign mem_we = (state_q == S_RESP) && op_wr_q && !proc_reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            line_mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = (state_q == S_RESP);
    assign bus.proto_err = err_q;
endmodule
